// File: rtl/memory_col_arbiter.sv
// Round-robin arbiter/sequencer sharing one byte-wide memory column.
// Define MEMCOL_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module memory_col_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 10,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [7:0]                rsp_rdata,
  output logic                      mem_byte_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [7:0]                mem_wr_data,
  input  logic [7:0]                mem_rd_data,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;

`ifdef MEMCOL_ARB_FIXED_PRIO_EN
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[IDX_W'(i)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] last_q, last_d;

  // Walk backwards so the nearest requester after last wins.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[IDX_W'(idx)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && win_vld) last_d = win_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= IDX_W'(NUM_REQ - 1);
    else     last_q <= last_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          req_ready[win_idx] = 1'b1;
          state_d = ISSUE;
          gnt_d   = win_idx;
          we_d    = req_we[win_idx];
          addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[win_idx*8 +: 8];
        end
      end
      ISSUE: begin
        if (we_q) begin
          rdata_d = 8'h00;
          state_d = RESP;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          rdata_d = mem_rd_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Column address/data double as the latched request, so they hold between accesses.
  assign mem_byte_en = (state_q == ISSUE) && we_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_memory_col_arbiter.sv
// Scoreboard bench for memory_col_arbiter with a behavioural column model.
module tb_memory_col_arbiter;

  localparam int NR = 2;
  localparam int AW = 10;
  localparam int RL = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready, req_we;
  logic [NR-1:0]    rsp_valid, rsp_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*8-1:0]  req_wdata;
  logic [7:0]       rsp_rdata, mem_wr_data, mem_rd_data;
  logic             mem_byte_en, busy;
  logic [AW-1:0]    mem_addr;

  always #5 clk = ~clk;

  memory_col_arbiter #(
    .NUM_REQ(NR),
    .ADDR_W (AW),
    .RD_LAT (RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .mem_byte_en(mem_byte_en),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .busy       (busy)
  );

  typedef struct {
    int         idx;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         grant_log[$];
  logic [7:0] mem_model [1024] = '{default: 8'h00};
  logic [7:0] ref_mem   [1024] = '{default: 8'h00};
  int         errs = 0;
  int         checks = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         rsp_lat = -1;
  bit         rsp_seen = 1'b0;
  int         be_cnt = 0;
  logic [AW-1:0] be_addr = '0;
  logic [7:0]    be_data = '0;
  int         acc_n = 0;
  int         rsp_n = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Column model: one-cycle registered read, write on byte_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_byte_en) mem_model[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem_model[mem_addr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_byte_en) begin
        be_cnt++;
        be_addr = mem_addr;
        be_data = mem_wr_data;
      end
      if (req_ready != '0) check("ready_onehot", 32'($onehot(req_ready)), 1);
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_log.push_back(i);
          acc_n++;
          acc_cyc  = cyc;
          rsp_seen = 1'b0;
          if (req_we[i]) begin
            ref_mem[req_addr[i*AW +: AW]] = req_wdata[i*8 +: 8];
            exp_q.push_back('{i, 8'h00});
          end else begin
            exp_q.push_back('{i, ref_mem[req_addr[i*AW +: AW]]});
          end
        end
      end
      if (rsp_valid != '0) begin
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          rsp_lat  = cyc - acc_cyc;
        end
        for (int i = 0; i < NR; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            if (exp_q.size() == 0) begin
              check("rsp_unexpected", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("rsp_idx", i, e.idx);
              check("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
              rsp_n++;
            end
          end
        end
      end
    end
  end

  task automatic arm(int i, bit we, logic [AW-1:0] a, logic [7:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*8 +: 8]   = d;
  endtask

  task automatic wait_acc(int i);
    int   n = 0;
    logic hit = 1'b0;
    while (!hit && n < 100) begin
      @(negedge clk);
      hit = req_ready[i];
      @(posedge clk);
      #1;
      n++;
    end
    req_valid[i] = 1'b0;
    if (!hit) check("acc_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", 0, 1);
  endtask

  task automatic traffic(int n, bit rnd);
    int            acc = 0;
    int            t = 0;
    logic [NR-1:0] a;
    while (acc < n && t < 5000) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && (!rnd || $urandom_range(1, 0) == 1))
          arm(i, rnd ? 1'($urandom_range(1, 0)) : 1'b0,
              AW'($urandom_range(15, 0)), 8'($urandom));
      end
      if (rnd) rsp_ready = NR'($urandom);
      @(negedge clk);
      a = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (a[i]) begin
          req_valid[i] = 1'b0;
          acc++;
        end
      end
      t++;
    end
    req_valid = '0;
    rsp_ready = '1;
    if (acc < n) check("traffic_timeout", acc, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0, g0, a0, r0, n, exp_g;
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_byte_en", mem_byte_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wr_data, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);

    b0 = be_cnt;
    arm(0, 1'b1, 10'h005, 8'hA5);
    wait_acc(0);
    drain();
    check("wr_be_pulses", be_cnt - b0, 1);
    check("wr_be_addr", be_addr, 10'h005);
    check("wr_be_data", be_data, 8'hA5);
    check("wr_rsp_lat", rsp_lat, 2);
    check("addr_hold", mem_addr, 10'h005);
    check("wr_idle_be", mem_byte_en, 0);

    arm(1, 1'b1, 10'h3FF, 8'h3C);
    wait_acc(1);
    drain();
    arm(1, 1'b0, 10'h3FF, 8'h00);
    wait_acc(1);
    drain();
    check("rd_rsp_lat", rsp_lat, 2 + RL);
    check("rd_data_hold", rsp_rdata, 8'h3C);

    arm(0, 1'b1, 10'h010, 8'h77);
    wait_acc(0);
    drain();
    rsp_ready = '0;
    arm(0, 1'b0, 10'h010, 8'h00);
    wait_acc(0);
    arm(1, 1'b0, 10'h005, 8'h00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[0] && n < 50);
    check("bp_rsp_seen", rsp_valid[0], 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 2'b01);
      check("bp_rsp_rdata", rsp_rdata, 8'h77);
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = '1;
    wait_acc(1);
    drain();

    arm(0, 1'b0, 10'h3FF, 8'h00);
    wait_acc(0);
    @(posedge clk);
    #1;
    check("in_wait_busy", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("wrst_busy", busy, 0);
    check("wrst_rsp_valid", rsp_valid, 0);

    g0 = grant_log.size();
    traffic(6, 1'b0);
    drain();
    for (int k = 0; k < 6; k++) begin
`ifdef MEMCOL_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = k % 2;
`endif
      if (grant_log.size() > g0 + k) check("grant_order", grant_log[g0+k], exp_g);
      else check("grant_missing", 0, 1);
    end

    a0 = acc_n;
    r0 = rsp_n;
    traffic(100, 1'b1);
    drain();
    check("rand_acc_n", acc_n - a0, 100);
    check("rand_rsp_n", rsp_n - r0, 100);
    check("rand_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
